// File: rtl/gauss_window_gen.sv
// ---------------------------------------------------------------------------
// gauss_window_gen
//
// Raster-to-window stage feeding the 3x3 Gaussian filter. Accepts an 8-bit
// grayscale stream in row-major order, keeps the two previous image lines in
// line buffers and emits every fully-populated 3x3 neighbourhood (no border
// padding) under a valid/ready handshake.
//
// Parameters
//   WIDTH, HEIGHT   image size in pixels / lines (both >= 3)
//
// Ports
//   clk_i_w         clock, rising edge
//   rst_i_w         asynchronous active-high reset
//   pix_valid_i     input pixel valid
//   pix_i           input pixel (unsigned 8-bit)
//   sof_i           start of frame: the accepted pixel is (0,0)
//   pix_ready_o     stage accepts a pixel this cycle
//   data_o_0..8     window, data_o_k = pixel (r + k/3, c + k%3)
//   win_valid_o     window outputs valid
//   win_ready_i     consumer takes the presented window
//   win_row_o       top-left row r of the presented window
//   win_col_o       top-left column c of the presented window
//   frame_done_o    one-cycle pulse with the first cycle of the last window
// ---------------------------------------------------------------------------
module gauss_window_gen #(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic                      clk_i_w,
  input  logic                      rst_i_w,
  input  logic                      pix_valid_i,
  input  logic [7:0]                pix_i,
  input  logic                      sof_i,
  output logic                      pix_ready_o,
  output logic [7:0]                data_o_0,
  output logic [7:0]                data_o_1,
  output logic [7:0]                data_o_2,
  output logic [7:0]                data_o_3,
  output logic [7:0]                data_o_4,
  output logic [7:0]                data_o_5,
  output logic [7:0]                data_o_6,
  output logic [7:0]                data_o_7,
  output logic [7:0]                data_o_8,
  output logic                      win_valid_o,
  input  logic                      win_ready_i,
  output logic [$clog2(HEIGHT)-1:0] win_row_o,
  output logic [$clog2(WIDTH)-1:0]  win_col_o,
  output logic                      frame_done_o
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

  // One vertical slice of the window: [0] = line row-2, [1] = row-1, [2] = row.
  typedef logic [2:0][7:0] column_t;

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic [7:0] lb0 [WIDTH];  // line row-2
  logic [7:0] lb1 [WIDTH];  // line row-1

  column_t tap_col0;        // window column c   (two accepts ago)
  column_t tap_col1;        // window column c+1 (previous accept)
  column_t new_col;         // window column c+2 (this accept)

  logic [8:0][7:0] data_q;

  logic          accept;
  logic [CW-1:0] cur_col;
  logic [RW-1:0] cur_row;
  logic          last_col;
  logic          last_row;
  logic          win_hit;

  assign pix_ready_o = ~win_valid_o | win_ready_i;
  assign accept      = pix_valid_i & pix_ready_o;

  // sof_i overrides the counters so a resynchronising pixel lands at (0,0).
  assign cur_col  = sof_i ? '0 : col;
  assign cur_row  = sof_i ? '0 : row;
  assign last_col = (cur_col == CW'(WIDTH - 1));
  assign last_row = (cur_row == RW'(HEIGHT - 1));
  assign win_hit  = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));

  assign new_col = {pix_i, lb1[cur_col], lb0[cur_col]};

  // NOTE: the line buffers carry no reset so they map onto plain RAM; rows 0-1
  // of each frame never emit windows, so stale contents are never observed.
  always_ff @(posedge clk_i_w) begin
    if (accept) begin
      lb0[cur_col] <= lb1[cur_col];
      lb1[cur_col] <= pix_i;
    end
  end

  // NOTE: every clocked state update uses non-blocking assignment so all
  // registers sample the same pre-edge values regardless of statement order.
  always_ff @(posedge clk_i_w or posedge rst_i_w) begin
    if (rst_i_w) begin
      col      <= '0;
      row      <= '0;
      tap_col0 <= '0;
      tap_col1 <= '0;
    end else if (accept) begin
      tap_col0 <= tap_col1;
      tap_col1 <= new_col;
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : cur_row + RW'(1);
      end else begin
        col <= cur_col + CW'(1);
        row <= cur_row;
      end
    end
  end

  // Output register: loads on a window-completing accept, otherwise holds
  // until the consumer takes the window. A load in the consume cycle replaces
  // the old window without a bubble.
  always_ff @(posedge clk_i_w or posedge rst_i_w) begin
    if (rst_i_w) begin
      data_q       <= '0;
      win_valid_o  <= 1'b0;
      win_row_o    <= '0;
      win_col_o    <= '0;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      if (win_hit) begin
        data_q       <= {new_col[2], tap_col1[2], tap_col0[2],
                         new_col[1], tap_col1[1], tap_col0[1],
                         new_col[0], tap_col1[0], tap_col0[0]};
        win_valid_o  <= 1'b1;
        win_row_o    <= cur_row - RW'(2);
        win_col_o    <= cur_col - CW'(2);
        frame_done_o <= last_row & last_col;
      end else if (win_ready_i) begin
        win_valid_o  <= 1'b0;
      end
    end
  end

  assign data_o_0 = data_q[0];
  assign data_o_1 = data_q[1];
  assign data_o_2 = data_q[2];
  assign data_o_3 = data_q[3];
  assign data_o_4 = data_q[4];
  assign data_o_5 = data_q[5];
  assign data_o_6 = data_q[6];
  assign data_o_7 = data_q[7];
  assign data_o_8 = data_q[8];

endmodule

// File: tb/tb_gauss_window_gen.sv
// ---------------------------------------------------------------------------
// tb_gauss_window_gen
//
// Scoreboard bench for gauss_window_gen at WIDTH=8, HEIGHT=6. The driver
// records every sent pixel in an image model and, for each window-completing
// pixel, pushes the expected 3x3 window onto a queue. A monitor pops and
// compares on every consumed window. A ready controller applies a 5-cycle
// stall on window (1,2) of the third frame.
// ---------------------------------------------------------------------------
module tb_gauss_window_gen;

  localparam int W = 8;
  localparam int H = 6;

  typedef struct packed {
    logic [7:0]      row;
    logic [7:0]      col;
    logic [8:0][7:0] d;
    logic            last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_valid = 1'b0;
  logic [7:0] pix = '0;
  logic       sof = 1'b0;
  logic       pix_ready;
  logic [7:0] d0, d1, d2, d3, d4, d5, d6, d7, d8;
  logic       win_valid;
  logic       win_ready = 1'b1;
  logic [2:0] win_row;
  logic [2:0] win_col;
  logic       frame_done;

  logic [8:0][7:0] got;
  assign got = {d8, d7, d6, d5, d4, d3, d2, d1, d0};

  always #5 clk = ~clk;

  gauss_window_gen #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk_i_w      (clk),
    .rst_i_w      (rst),
    .pix_valid_i  (pix_valid),
    .pix_i        (pix),
    .sof_i        (sof),
    .pix_ready_o  (pix_ready),
    .data_o_0     (d0),
    .data_o_1     (d1),
    .data_o_2     (d2),
    .data_o_3     (d3),
    .data_o_4     (d4),
    .data_o_5     (d5),
    .data_o_6     (d6),
    .data_o_7     (d7),
    .data_o_8     (d8),
    .win_valid_o  (win_valid),
    .win_ready_i  (win_ready),
    .win_row_o    (win_row),
    .win_col_o    (win_col),
    .frame_done_o (frame_done)
  );

  int checks   = 0;
  int failures = 0;

  exp_t       sb[$];
  logic [7:0] img [H][W];
  int         br = 0;
  int         bc = 0;

  int              win_cnt = 0;
  int              fd_cnt  = 0;
  logic [8:0][7:0] first_d;
  logic [8:0][7:0] last_d;
  int              last_r;
  int              last_c;

  bit              stall_en   = 1'b0;
  int              stall_left = 5;
  logic [8:0][7:0] stall_exp;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Record the pixel in the image model, push any window it completes, then
  // hold it on the input until the DUT accepts it.
  task automatic send_pixel(input logic [7:0] v, input logic s);
    exp_t e;
    bit   acc;
    if (s) begin
      br = 0;
      bc = 0;
    end
    img[br][bc] = v;
    if (br >= 2 && bc >= 2) begin
      e.row  = 8'(br - 2);
      e.col  = 8'(bc - 2);
      for (int k = 0; k < 9; k++) e.d[k] = img[br - 2 + k / 3][bc - 2 + k % 3];
      e.last = (br == H - 1) && (bc == W - 1);
      sb.push_back(e);
    end
    if (bc == W - 1) begin
      bc = 0;
      br = (br == H - 1) ? 0 : br + 1;
    end else begin
      bc++;
    end
    acc = 1'b0;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk);
      pix_valid = 1'b1;
      pix       = v;
      sof       = s;
      #1;
      acc = pix_ready;
      @(posedge clk);
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout pixel=%0d", v);
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    pix_valid = 1'b0;
    sof       = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && sb.size() != 0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("drain_empty", sb.size(), 0);
  endtask

  // Ready controller: stalls window (1,2) for five cycles when enabled.
  initial begin
    stall_exp = {8'd28, 8'd27, 8'd26, 8'd20, 8'd19, 8'd18, 8'd12, 8'd11, 8'd10};
    forever begin
      @(negedge clk);
      if (stall_en && stall_left > 0 && win_valid && win_row == 3'd1 && win_col == 3'd2) begin
        win_ready = 1'b0;
        stall_left--;
        #1;
        check("stall_pix_ready", pix_ready, 1'b0);
        check("stall_data", got, stall_exp);
      end else begin
        win_ready = 1'b1;
      end
    end
  end

  // Monitor: compare each consumed window against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (frame_done) fd_cnt++;
        if (win_valid && win_ready) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_window row=%0d col=%0d", win_row, win_col);
          end else begin
            e = sb.pop_front();
            check("win_row", win_row, e.row[2:0]);
            check("win_col", win_col, e.col[2:0]);
            check("win_data", got, e.d);
            check("frame_done", frame_done, e.last);
            win_cnt++;
            if (win_cnt == 1) first_d = got;
            last_d = got;
            last_r = int'(win_row);
            last_c = int'(win_col);
          end
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with random inputs: outputs must stay cleared.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pix_valid = 1'($urandom);
      pix       = 8'($urandom);
      sof       = 1'($urandom);
      #1;
      check("rst_data", got, '0);
      check("rst_valid", win_valid, 1'b0);
      check("rst_frame_done", frame_done, 1'b0);
      check("rst_coords", {win_row, win_col}, 6'd0);
      check("rst_pix_ready", pix_ready, 1'b1);
    end
    @(negedge clk);
    pix_valid = 1'b0;
    sof       = 1'b0;
    rst       = 1'b0;
    repeat (2) @(negedge clk);

    // Frame 1: ramp, consumer always ready.
    for (int n = 0; n < W * H; n++) begin
      send_pixel(8'(n), 1'b0);
      #1;
      if (n == 17) check("pre_first_valid", win_valid, 1'b0);
      if (n == 18) begin
        check("first_valid", win_valid, 1'b1);
        check("first_coords", {win_row, win_col}, 6'd0);
      end
    end
    go_idle();
    drain();
    check("f1_windows", win_cnt, 24);
    check("f1_first_data", first_d,
          {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0});
    check("f1_last_data", last_d,
          {8'd47, 8'd46, 8'd45, 8'd39, 8'd38, 8'd37, 8'd31, 8'd30, 8'd29});
    check("f1_last_row", last_r, 3);
    check("f1_last_col", last_c, 5);
    check("f1_frame_done_cnt", fd_cnt, 1);

    // Frame 2: 20 pixels only, then abandoned.
    for (int n = 0; n < 20; n++) send_pixel(8'(255 - n), n == 0);
    go_idle();
    drain();
    check("f2_windows", win_cnt, 26);

    // Frame 3: restart with sof, ramp again, stall on window (1,2).
    stall_en = 1'b1;
    for (int n = 0; n < W * H; n++) send_pixel(8'(n), n == 0);
    go_idle();
    drain();
    stall_en = 1'b0;
    check("f3_stall_done", stall_left, 0);
    check("total_windows", win_cnt, 50);
    check("total_frame_done", fd_cnt, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gauss_window_gen.md
# gauss_window_gen

Raster-to-window stage directly upstream of the Gaussian filter. It accepts an 8-bit grayscale pixel stream in row-major order and buffers two image lines internally. For every valid 3x3 neighbourhood with no border padding, it presents nine pixels to the filter's `data_i_0..data_i_8` inputs and holds them under a valid/ready handshake until the filter has consumed them.

## Interface
- `WIDTH`, default 320: image width in pixels (≥3)
- `HEIGHT`, default 240: image height in lines (≥3)
- `clk_i_w`  in  1: single clock, rising edge
- `rst_i_w`  in  1: asynchronous, active-high reset
- `pix_valid_i`  in  1: input pixel valid
- `pix_i`  in  8: input pixel, unsigned grayscale
- `sof_i`  in  1: start of frame; qualifies the accepted pixel as (0,0)
- `pix_ready_o`  out  1: stage can accept a pixel this cycle
- `data_o_0` … `data_o_8`  out  8 each: window; `0..2` = row r, cols c..c+2; `3..5` = row r+1; `6..8` = row r+2
- `win_valid_o`  out  1: window outputs valid; drives filter enable
- `win_ready_i`  in  1: consumer accepts window (filter `sonuc_done` / ready)
- `win_row_o`  out  $clog2(HEIGHT): top-left row r of the presented window
- `win_col_o`  out  $clog2(WIDTH): top-left column c of the presented window
- `frame_done_o`  out  1: one-cycle pulse, coincides with the last window of the frame

## Operation
- Accept condition: `pix_valid_i & pix_ready_o`, and `rst_i_w` low.
- `pix_ready_o = ~win_valid_o | win_ready_i` (combinational).
- Column counter `col` counts 0..WIDTH-1; row counter `row` counts 0..HEIGHT-1. Both advance on accept only. `col` wraps to 0 and increments `row`; at (HEIGHT-1, WIDTH-1) both wrap to 0.
- `sof_i` on an accepted pixel: that pixel is treated as (0,0) regardless of the counters, and the counters continue from (0,1).
- Line buffers: two WIDTH×8 memories. LB1 holds line row-1 and LB0 holds line row-2. On accept at column x:
  - read taps: LB0[x], LB1[x], pix_i
  - write: LB0[x] ← LB1[x], LB1[x] ← pix_i
- 3x3 shift register: on each accept, columns shift left and the new column {LB0[x], LB1[x], pix_i} enters at column 2. Contents are undefined at col<2; they are never emitted there.
- A window is produced when the accepted pixel has row≥2 and col≥2. Its top-left is (row-2, col-2).
- Windows per frame: (HEIGHT-2)·(WIDTH-2), in raster order of top-left. The default is 75684.
- Line buffers are not cleared by reset or `sof_i`; rows 0–1 of each frame produce no windows.
- Pixel ordering in the window: `data_o_k` = pixel (r + k/3, c + k%3).

## Timing
- Reset values: `data_o_*` = 0, `win_valid_o` = 0, `win_row_o` = 0, `win_col_o` = 0, `frame_done_o` = 0, counters = 0. `pix_ready_o` evaluates to 1.
- Latency: a window completed by a pixel accepted in cycle N is registered, with `win_valid_o`=1, in cycle N+1.
- Once `win_valid_o`=1, all window outputs and coordinates are held stable until a cycle with `win_ready_i`=1.
- In the consume cycle, if a window-completing pixel is also accepted, the next window replaces the current one in the following cycle with no bubble. Otherwise `win_valid_o` drops.
- `win_valid_o & ~win_ready_i` forces `pix_ready_o`=0. No pixel is accepted or lost while stalled.
- `frame_done_o` is high for exactly one cycle: the first cycle the (HEIGHT-3, WIDTH-3) window is presented.
- Reset asserted mid-frame clears all state and outputs asynchronously, and any pending window is discarded. The frame restarts at (0,0) after release.

## Test plan
- Reset: assert `rst_i_w` with random inputs → all `data_o_*`=0, `win_valid_o`=0, `frame_done_o`=0, no window produced.
- Ramp frame, WIDTH=8, HEIGHT=6, pixel=row·8+col, `win_ready_i`=1:
  - first window appears 1 cycle after the 19th accept, at (0,0)
  - data = 0,1,2,8,9,10,16,17,18
  - exactly 24 windows are produced
- Same frame, last window:
  - at (3,5), data = 29,30,31,37,38,39,45,46,47
  - `frame_done_o` pulses once with it
- Backpressure: hold `win_ready_i`=0 for 5 cycles on window (1,2) → `pix_ready_o`=0 throughout and data remains 10,11,12,18,19,20,26,27,28. After release, the window sequence continues with (1,3) and no gaps.
- `sof_i` after 20 accepted pixels → no window until the new (2,2) pixel; the next window reports (0,0) with the new frame's data.
- Default 320×240 frame read from `gauss_input_gray.mem` → 75684 windows, matching a software 3x3 window sweep in raster order.
